aplic_msi_sched: RTL and testbench
==================================

APLIC_MSI_SCHED -- requirements
Module: aplic_msi_sched

Interface
REQ-001 SHALL have parameter NR_SRC, default 64, number of interrupt sources including unused source 0, legal range 2..1024.
REQ-002 SHALL have parameter SRC_W, default $clog2(NR_SRC), source index width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have i_ie  in  1  domaincfg.IE; i_dm  in  1  domaincfg.DM, 1 = MSI mode.
REQ-006 SHALL have i_pending  in  NR_SRC  pending bits; i_enabled  in  NR_SRC  enable bits; bit 0 ignored.
REQ-007 SHALL have o_tgt_idx  out  SRC_W  target register select; i_tgt  in  32  selected target word, combinational, same cycle.
REQ-008 SHALL have i_msi_base  in  64  MSI base address for hart index 0.
REQ-009 SHALL have i_gen_we  in  1  genmsi write strobe; i_gen_wdata  in  32  genmsi write data; o_gen_busy  out  1  genmsi.busy.
REQ-010 SHALL have o_clr_valid  out  1  pending-clear pulse; o_clr_idx  out  SRC_W  source to clear.
REQ-011 SHALL have o_msi_valid  out  1; i_msi_ready  in  1; o_msi_addr  out  64; o_msi_data  out  32.

Function
REQ-012 SHALL implement states SCAN, FETCH, SEND_SRC, SEND_GEN; reset state SCAN.
REQ-013 In SCAN with i_dm=1, a captured genmsi request SHALL go to SEND_GEN next cycle, with priority over sources.
REQ-014 Otherwise in SCAN, if i_ie, i_pending[ptr] and i_enabled[ptr] are all 1, SHALL go to FETCH; else ptr SHALL advance by 1, wrapping from NR_SRC-1 to 1.
REQ-015 In FETCH, o_tgt_idx SHALL equal ptr; i_tgt fields hi[31:18] and eiid[10:0] SHALL be registered.
REQ-016 If the registered eiid = 0, SHALL skip the write, pulse o_clr_valid for one cycle with o_clr_idx=ptr, advance ptr, and return to SCAN.
REQ-017 Otherwise SHALL enter SEND_SRC: o_msi_valid=1, o_msi_addr = i_msi_base + {hi,12'h000} (64-bit wrap), o_msi_data = {21'b0, eiid}.
REQ-018 o_msi_addr and o_msi_data SHALL be held stable while o_msi_valid=1 and i_msi_ready=0; o_msi_addr SHALL use i_msi_base as sampled at the FETCH/capture edge.
REQ-019 On the SEND_SRC handshake (valid & ready), SHALL pulse o_clr_valid with o_clr_idx=ptr in the same cycle, advance ptr, and go to SCAN.
REQ-020 i_gen_we with o_gen_busy=0 SHALL capture hi=i_gen_wdata[31:18] and eiid=i_gen_wdata[10:0] and set o_gen_busy next cycle.
REQ-021 i_gen_we with o_gen_busy=1 SHALL be ignored.
REQ-022 SEND_GEN SHALL drive addr/data as in REQ-017 from the genmsi fields, including eiid 0.
REQ-023 SEND_GEN SHALL produce no o_clr_valid.
REQ-024 On the SEND_GEN handshake, SHALL clear o_gen_busy the next cycle and go to SCAN.
REQ-025 If i_ie drops during FETCH or SEND_SRC, the started transaction SHALL complete; no new source SHALL be selected while i_ie=0.
REQ-026 While i_dm=0, SHALL issue no MSI; genmsi writes SHALL be ignored; ptr SHALL keep scanning with no FETCH.
REQ-027 Latency from a source becoming eligible at ptr to o_msi_valid SHALL be 2 cycles (SCAN->FETCH->SEND_SRC).
REQ-028 Worst-case scan latency SHALL be NR_SRC-1 cycles plus any outstanding transaction.

Reset
REQ-029 When i_rst=1 at a clock edge, SHALL set state=SCAN, ptr=1, o_msi_valid=0, o_clr_valid=0, o_gen_busy=0, and captured genmsi/target fields to 0.
REQ-030 Reset mid-transaction SHALL drop o_msi_valid on the next cycle without a handshake and without a clear pulse.
REQ-031 o_tgt_idx, o_msi_addr, o_msi_data, and o_clr_idx SHALL be 0 after reset.

Verification
REQ-032 Scenario: ie=1, dm=1, pending/enabled bit 5 set, target[5] hi=3 eiid=0x2A, base=0x2800_0000, ready=1 -> addr 0x2800_3000, data 0x2A, clear pulse idx 5.
REQ-033 Scenario: bits 2 and 60 pending; hold ready=0 for 4 cycles on source 2 -> valid and addr stable throughout; then source 60 served after the handshake; ptr wraps 63->1.
REQ-034 Scenario: genmsi write hi=1 eiid=7 while source 9 is eligible -> genmsi MSI first (addr base+0x1000, data 7); busy=1 until the cycle after the handshake; a second write while busy is ignored.
REQ-035 Scenario: target eiid=0 for source 4 -> no o_msi_valid; one-cycle clear pulse idx 4.
REQ-036 Scenario: i_rst asserted during SEND_SRC with ready=0 -> o_msi_valid=0 the next cycle; no clear pulse; ptr=1.
REQ-037 Scenario: dm=0 with sources pending -> no MSI and no clear for 200 cycles.

Source files
------------

// File: rtl/aplic_msi_sched.sv
//------------------------------------------------------------------------------
// aplic_msi_sched: round-robin APLIC source scanner that turns pending/enabled
// sources and genmsi writes into MSI write requests.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aplic_msi_sched #(
    parameter int NR_SRC = 64,
    parameter int SRC_W  = $clog2(NR_SRC)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ie,
    input  logic              i_dm,
    input  logic [NR_SRC-1:0] i_pending,
    input  logic [NR_SRC-1:0] i_enabled,
    output logic [SRC_W-1:0]  o_tgt_idx,
    input  logic [31:0]       i_tgt,
    input  logic [63:0]       i_msi_base,
    input  logic              i_gen_we,
    input  logic [31:0]       i_gen_wdata,
    output logic              o_gen_busy,
    output logic              o_clr_valid,
    output logic [SRC_W-1:0]  o_clr_idx,
    output logic              o_msi_valid,
    input  logic              i_msi_ready,
    output logic [63:0]       o_msi_addr,
    output logic [31:0]       o_msi_data
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        FETCH    = 2'd1,
        SEND_SRC = 2'd2,
        SEND_GEN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] ptr_nxt;
    logic [SRC_W-1:0] ptr_inc;
    logic             gen_busy;
    logic [13:0]      gen_hi;
    logic [10:0]      gen_eiid;
    logic [63:0]      msi_addr;
    logic [31:0]      msi_data;
    logic             eligible;
    logic             gen_capture;
    logic             gen_done;
    logic             load_src;
    logic             load_gen;
    logic             clr;

    // Source 0 and the reserved target/genmsi bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{i_pending[0], i_enabled[0], i_tgt[17:11], i_gen_wdata[17:11]};

    assign ptr_inc     = (ptr == SRC_W'(NR_SRC - 1)) ? SRC_W'(1) : ptr + SRC_W'(1);
    assign eligible    = i_ie & i_dm & i_pending[ptr] & i_enabled[ptr];
    assign gen_capture = i_gen_we & ~gen_busy & i_dm;
    assign gen_done    = (state == SEND_GEN) & i_msi_ready;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load_src  = 1'b0;
        load_gen  = 1'b0;
        clr       = 1'b0;
        case (state)
            SCAN: begin
                if (i_dm && gen_busy) begin
                    state_nxt = SEND_GEN;
                    load_gen  = 1'b1;
                end else if (eligible) begin
                    state_nxt = FETCH;
                end else begin
                    ptr_nxt = ptr_inc;
                end
            end
            FETCH: begin
                // A zero EIID means the source is silently retired.
                if (i_tgt[10:0] == 11'd0) begin
                    clr       = 1'b1;
                    ptr_nxt   = ptr_inc;
                    state_nxt = SCAN;
                end else begin
                    load_src  = 1'b1;
                    state_nxt = SEND_SRC;
                end
            end
            SEND_SRC: begin
                if (i_msi_ready) begin
                    clr       = 1'b1;
                    ptr_nxt   = ptr_inc;
                    state_nxt = SCAN;
                end
            end
            SEND_GEN: begin
                if (i_msi_ready) begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= SCAN;
            ptr      <= SRC_W'(1);
            gen_busy <= 1'b0;
            gen_hi   <= '0;
            gen_eiid <= '0;
            msi_addr <= '0;
            msi_data <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (gen_capture) begin
                gen_busy <= 1'b1;
                gen_hi   <= i_gen_wdata[31:18];
                gen_eiid <= i_gen_wdata[10:0];
            end else if (gen_done) begin
                gen_busy <= 1'b0;
            end
            // Address is frozen at capture so base changes cannot disturb a held request.
            if (load_src) begin
                msi_addr <= i_msi_base + {38'd0, i_tgt[31:18], 12'h000};
                msi_data <= {21'd0, i_tgt[10:0]};
            end else if (load_gen) begin
                msi_addr <= i_msi_base + {38'd0, gen_hi, 12'h000};
                msi_data <= {21'd0, gen_eiid};
            end
        end
    end

    assign o_tgt_idx   = (state == FETCH) ? ptr : '0;
    assign o_clr_valid = clr;
    assign o_clr_idx   = clr ? ptr : '0;
    assign o_msi_valid = (state == SEND_SRC) || (state == SEND_GEN);
    assign o_msi_addr  = msi_addr;
    assign o_msi_data  = msi_data;
    assign o_gen_busy  = gen_busy;

endmodule

`default_nettype wire

// File: tb/tb_aplic_msi_sched.sv
//------------------------------------------------------------------------------
// tb_aplic_msi_sched: directed self-checking bench for aplic_msi_sched.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aplic_msi_sched;

    localparam int NR_SRC = 64;
    localparam int SRC_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              ie;
    logic              dm;
    logic [NR_SRC-1:0] pending;
    logic [NR_SRC-1:0] enabled;
    logic [SRC_W-1:0]  tgt_idx;
    logic [31:0]       tgt;
    logic [63:0]       msi_base;
    logic              gen_we;
    logic [31:0]       gen_wdata;
    logic              gen_busy;
    logic              clr_valid;
    logic [SRC_W-1:0]  clr_idx;
    logic              msi_valid;
    logic              msi_ready;
    logic [63:0]       msi_addr;
    logic [31:0]       msi_data;

    logic [31:0] tgt_mem [NR_SRC];
    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    assign tgt = tgt_mem[tgt_idx];

    aplic_msi_sched #(.NR_SRC(NR_SRC), .SRC_W(SRC_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ie        (ie),
        .i_dm        (dm),
        .i_pending   (pending),
        .i_enabled   (enabled),
        .o_tgt_idx   (tgt_idx),
        .i_tgt       (tgt),
        .i_msi_base  (msi_base),
        .i_gen_we    (gen_we),
        .i_gen_wdata (gen_wdata),
        .o_gen_busy  (gen_busy),
        .o_clr_valid (clr_valid),
        .o_clr_idx   (clr_idx),
        .o_msi_valid (msi_valid),
        .i_msi_ready (msi_ready),
        .o_msi_addr  (msi_addr),
        .o_msi_data  (msi_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n;
        n = 0;
        while (!msi_valid && n < max) begin
            step();
            n++;
        end
        check(tag, msi_valid, 1'b1);
    endtask

    initial begin
        int n, v, c, f, b;
        rst = 1'b1; ie = 1'b0; dm = 1'b0; pending = '0; enabled = '0;
        msi_base = '0; gen_we = 1'b0; gen_wdata = '0; msi_ready = 1'b0;
        for (int i = 0; i < NR_SRC; i++) tgt_mem[i] = '0;

        // Reset state
        step();
        step();
        check("rst_valid", msi_valid, 0);
        check("rst_busy", gen_busy, 0);
        check("rst_clr", clr_valid, 0);
        check("rst_clr_idx", clr_idx, 0);
        check("rst_tgt_idx", tgt_idx, 0);
        check("rst_addr", msi_addr, 0);
        check("rst_data", msi_data, 0);
        check("rst_ptr", dut.ptr, 1);

        // Basic source 5 delivery
        rst = 1'b0; ie = 1'b1; dm = 1'b1; msi_ready = 1'b1;
        msi_base = 64'h2800_0000;
        tgt_mem[5] = 32'h000C_002A;
        pending[5] = 1'b1; enabled[5] = 1'b1;
        n = 0;
        while (tgt_idx == 0 && n < 70) begin step(); n++; end
        check("a_fetch_idx", tgt_idx, 5);
        check("a_fetch_novalid", msi_valid, 0);
        step();
        check("a_valid", msi_valid, 1);
        check("a_addr", msi_addr, 64'h2800_3000);
        check("a_data", msi_data, 32'h2A);
        check("a_clr", clr_valid, 1);
        check("a_clr_idx", clr_idx, 5);
        pending[5] = 1'b0;
        step();
        check("a_valid_drop", msi_valid, 0);
        check("a_clr_drop", clr_valid, 0);

        // Back-pressure on source 2, then source 60, then pointer wrap
        do_reset();
        msi_ready = 1'b0;
        tgt_mem[2]  = 32'h0004_0011;
        tgt_mem[60] = 32'hFFFC_07FF;
        pending[2] = 1'b1; enabled[2] = 1'b1;
        pending[60] = 1'b1; enabled[60] = 1'b1;
        wait_valid(10, "b_wait2");
        msi_base = 64'h1234_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("b_hold_valid", msi_valid, 1);
            check("b_hold_addr", msi_addr, 64'h2800_1000);
            check("b_hold_data", msi_data, 32'h11);
            check("b_hold_noclr", clr_valid, 0);
        end
        msi_base = 64'h2800_0000;
        msi_ready = 1'b1;
        #1;
        check("b_clr2", clr_valid, 1);
        check("b_clr2_idx", clr_idx, 2);
        pending[2] = 1'b0;
        step();
        wait_valid(80, "b_wait60");
        check("b_addr60", msi_addr, 64'h2BFF_F000);
        check("b_data60", msi_data, 32'h7FF);
        check("b_clr60_idx", clr_idx, 60);
        pending[60] = 1'b0;
        n = 0;
        while (dut.ptr != 63 && n < 10) begin step(); n++; end
        check("b_ptr63", dut.ptr, 63);
        step();
        check("b_ptr_wrap", dut.ptr, 1);

        // genmsi takes priority over eligible source 9; second write ignored
        do_reset();
        tgt_mem[9] = 32'h0008_0033;
        pending[9] = 1'b1; enabled[9] = 1'b1;
        gen_we = 1'b1; gen_wdata = 32'h0004_0007;
        step();
        check("c_busy_set", gen_busy, 1);
        gen_wdata = 32'h000C_0005;
        msi_ready = 1'b0;
        step();
        gen_we = 1'b0;
        check("c_gen_valid", msi_valid, 1);
        check("c_gen_addr", msi_addr, 64'h2800_1000);
        check("c_gen_data", msi_data, 32'h7);
        check("c_busy_hold", gen_busy, 1);
        msi_ready = 1'b1;
        #1;
        check("c_gen_noclr", clr_valid, 0);
        check("c_busy_hs", gen_busy, 1);
        step();
        check("c_busy_clear", gen_busy, 0);
        check("c_valid_drop", msi_valid, 0);
        wait_valid(20, "c_wait9");
        check("c_src9_data", msi_data, 32'h33);
        check("c_src9_addr", msi_addr, 64'h2800_2000);
        check("c_src9_clr_idx", clr_idx, 9);
        pending[9] = 1'b0;
        step();

        // Zero EIID: clear pulse only
        do_reset();
        tgt_mem[4] = 32'h0014_0000;
        pending[4] = 1'b1; enabled[4] = 1'b1;
        v = 0; c = 0; n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (msi_valid) v++;
            if (clr_valid) begin c++; n = int'(clr_idx); end
        end
        check("d_no_valid", v, 0);
        check("d_one_clr", c, 1);
        check("d_clr_idx", n, 4);
        pending[4] = 1'b0;

        // Reset during a held SEND_SRC; base wraps at 64 bits
        do_reset();
        msi_ready = 1'b0;
        msi_base = 64'hFFFF_FFFF_FFFF_F000;
        tgt_mem[3] = 32'h0008_0003;
        pending[3] = 1'b1; enabled[3] = 1'b1;
        wait_valid(10, "e_wait3");
        check("e_wrap_addr", msi_addr, 64'h1000);
        rst = 1'b1;
        #1;
        check("e_noclr_pre", clr_valid, 0);
        step();
        check("e_valid_drop", msi_valid, 0);
        check("e_noclr", clr_valid, 0);
        check("e_ptr", dut.ptr, 1);
        check("e_addr_zero", msi_addr, 0);
        rst = 1'b0;
        pending[3] = 1'b0;
        msi_base = 64'h2800_0000;

        // IE dropped mid-transaction: finish it, then select nothing
        do_reset();
        tgt_mem[6] = 32'h0000_0006;
        pending[6] = 1'b1; enabled[6] = 1'b1;
        wait_valid(10, "g_wait6");
        ie = 1'b0;
        step();
        check("g_valid_kept", msi_valid, 1);
        msi_ready = 1'b1;
        #1;
        check("g_clr", clr_valid, 1);
        check("g_clr_idx", clr_idx, 6);
        f = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (tgt_idx != 0 || msi_valid) f++;
        end
        check("g_no_select", f, 0);
        pending[6] = 1'b0;
        ie = 1'b1;

        // Direct mode: nothing issued, genmsi ignored
        do_reset();
        dm = 1'b0;
        tgt_mem[7] = 32'h0000_0017;
        tgt_mem[40] = 32'h0000_0028;
        pending[7] = 1'b1; enabled[7] = 1'b1;
        pending[40] = 1'b1; enabled[40] = 1'b1;
        pending[3] = 1'b1; enabled[3] = 1'b1;
        gen_we = 1'b1; gen_wdata = 32'h0004_0007;
        v = 0; c = 0; f = 0; b = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (msi_valid) v++;
            if (clr_valid) c++;
            if (tgt_idx != 0) f++;
            if (gen_busy) b++;
        end
        check("f_no_msi", v, 0);
        check("f_no_clr", c, 0);
        check("f_no_fetch", f, 0);
        check("f_no_busy", b, 0);
        gen_we = 1'b0;
        pending = '0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
